// File: rtl/dct_seq_pkg.sv
// Shared state encoding, default widths and a width helper for the DCT tile sequencer.
package dct_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } seqState_e;

  localparam int DEF_BLK    = 8;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_COEF_W = 16;

  // Never returns less than 1 so counters of a single value still get a legal width.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    if (result < 1) begin
      result = 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/dct_tile_addr_gen.sv
// Tile-order address walker: column fastest, then row, then tile x, then tile y.
// The address is kept incrementally so no multiplier is needed.
module dct_tile_addr_gen
  import dct_seq_pkg::*;
#(
  parameter int IMG_W  = 128,
  parameter int IMG_H  = 128,
  parameter int BLK    = DEF_BLK,
  parameter int ADDR_W = 14
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              clear_i,
  input  logic              step_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_o
);

  localparam int NBX = IMG_W / BLK;
  localparam int NBY = IMG_H / BLK;
  localparam int PW  = clog2(BLK);
  localparam int XW  = clog2(NBX);
  localparam int YW  = clog2(NBY);

  localparam logic [PW-1:0] PMAX = PW'(BLK - 1);
  localparam logic [XW-1:0] XMAX = XW'(NBX - 1);
  localparam logic [YW-1:0] YMAX = YW'(NBY - 1);

  // Jumps from the last pixel of a tile row to the next row, and from a tile's last pixel to the next tile.
  localparam logic [ADDR_W-1:0] ROW_INC  = ADDR_W'(IMG_W - BLK + 1);
  localparam logic [ADDR_W-1:0] TILE_INC = ADDR_W'(1 - (BLK - 1) * IMG_W);

  logic [PW-1:0]     col_q, col_d, row_q, row_d;
  logic [XW-1:0]     bx_q, bx_d;
  logic [YW-1:0]     by_q, by_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    bx_d   = bx_q;
    by_d   = by_q;
    addr_d = addr_q;
    if (clear_i) begin
      col_d  = '0;
      row_d  = '0;
      bx_d   = '0;
      by_d   = '0;
      addr_d = '0;
    end else if (step_i) begin
      if (col_q != PMAX) begin
        col_d  = col_q + PW'(1);
        addr_d = addr_q + ADDR_W'(1);
      end else begin
        col_d = '0;
        if (row_q != PMAX) begin
          row_d  = row_q + PW'(1);
          addr_d = addr_q + ROW_INC;
        end else begin
          row_d = '0;
          if (bx_q != XMAX) begin
            bx_d   = bx_q + XW'(1);
            addr_d = addr_q + TILE_INC;
          end else begin
            // The end of a tile row is the end of a raster row, so the next tile row follows directly.
            bx_d   = '0;
            addr_d = addr_q + ADDR_W'(1);
            if (by_q != YMAX) begin
              by_d = by_q + YW'(1);
            end else begin
              by_d   = '0;
              addr_d = '0;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      col_q  <= '0;
      row_q  <= '0;
      bx_q   <= '0;
      by_q   <= '0;
      addr_q <= '0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      bx_q   <= bx_d;
      by_q   <= by_d;
      addr_q <= addr_d;
    end
  end

  assign addr_o = addr_q;
  assign last_o = (col_q == PMAX) && (row_q == PMAX) && (bx_q == XMAX) && (by_q == YMAX);

endmodule

// File: rtl/dct_tile_sequencer.sv
// Frame sequencer: streams an image tile by tile into the DCT core and writes the
// returned coefficients back at the same tiled addresses, then pulses done.
module dct_tile_sequencer
  import dct_seq_pkg::*;
#(
  parameter int IMG_W  = 128,
  parameter int IMG_H  = 128,
  parameter int BLK    = DEF_BLK,
  parameter int DATA_W = DEF_DATA_W,
  parameter int COEF_W = DEF_COEF_W,
  parameter int ADDR_W = 14
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic              in_rd_o,
  output logic [ADDR_W-1:0] in_addr_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              s_valid_o,
  input  logic              s_ready_i,
  output logic [DATA_W-1:0] s_data_o,
  output logic              s_last_o,
  input  logic              m_valid_i,
  input  logic [COEF_W-1:0] m_data_i,
  input  logic              m_last_i,
  output logic              out_we_o,
  output logic [ADDR_W-1:0] out_addr_o,
  output logic [COEF_W-1:0] out_data_o
);

  localparam int BEAT_W = clog2(BLK * BLK);

  seqState_e         state_q, state_d;
  logic              rdPend_q, rdPend_d;
  logic [1:0]        fifoCnt_q, fifoCnt_d;
  logic              wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [DATA_W-1:0] fifoMem_q [2];
  logic [BEAT_W-1:0] beatCnt_q, beatCnt_d;
  logic              err_q, err_d, wrDone_q, wrDone_d;
  logic              startAcc, writeOpen, rdLast, wrLast;
  logic              push, popFifo, beatTaken;
  logic [ADDR_W-1:0] rdAddr, wrAddr;
  logic              unusedMLast;

  assign unusedMLast = m_last_i;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Reads are only issued while the skid FIFO is guaranteed room for the returning beat.
  always_comb begin
    state_d   = state_q;
    startAcc  = 1'b0;
    busy_o    = (state_q != ST_IDLE);
    done_o    = (state_q == ST_DONE);
    err_o     = err_q;
    writeOpen = ((state_q == ST_RUN) || (state_q == ST_DRAIN)) && !wrDone_q;
    out_we_o  = m_valid_i && writeOpen;
    in_rd_o   = (state_q == ST_RUN) && ((fifoCnt_q + {1'b0, rdPend_q}) < 2'd2);
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          startAcc = 1'b1;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        if (in_rd_o && rdLast) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (wrDone_q || (out_we_o && wrLast)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // An empty FIFO passes the arriving read beat straight through to the stream.
  always_comb begin
    s_valid_o  = (fifoCnt_q != 2'd0) || rdPend_q;
    s_data_o   = ((fifoCnt_q == 2'd0) && rdPend_q) ? in_data_i : fifoMem_q[rdPtr_q];
    s_last_o   = s_valid_o && (beatCnt_q == '1);
    beatTaken  = s_valid_o && s_ready_i;
    push       = rdPend_q && !((fifoCnt_q == 2'd0) && s_ready_i);
    popFifo    = (fifoCnt_q != 2'd0) && s_ready_i;
    rdPend_d   = in_rd_o;
    fifoCnt_d  = fifoCnt_q + {1'b0, push} - {1'b0, popFifo};
    wrPtr_d    = wrPtr_q ^ push;
    rdPtr_d    = rdPtr_q ^ popFifo;
    beatCnt_d  = beatTaken ? beatCnt_q + BEAT_W'(1) : beatCnt_q;
    wrDone_d   = wrDone_q | (out_we_o && wrLast);
    err_d      = err_q;
    in_addr_o  = rdAddr;
    out_addr_o = wrAddr;
    out_data_o = out_we_o ? m_data_i : '0;
    if (startAcc) begin
      fifoCnt_d = '0;
      wrPtr_d   = 1'b0;
      rdPtr_d   = 1'b0;
      beatCnt_d = '0;
      wrDone_d  = 1'b0;
      err_d     = 1'b0;
    end
    if (m_valid_i && !writeOpen) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rdPend_q     <= 1'b0;
      fifoCnt_q    <= '0;
      wrPtr_q      <= 1'b0;
      rdPtr_q      <= 1'b0;
      fifoMem_q[0] <= '0;
      fifoMem_q[1] <= '0;
      beatCnt_q    <= '0;
      err_q        <= 1'b0;
      wrDone_q     <= 1'b0;
    end else begin
      rdPend_q  <= rdPend_d;
      fifoCnt_q <= fifoCnt_d;
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      beatCnt_q <= beatCnt_d;
      err_q     <= err_d;
      wrDone_q  <= wrDone_d;
      if (push) begin
        fifoMem_q[wrPtr_q] <= in_data_i;
      end
    end
  end

  dct_tile_addr_gen #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .BLK   (BLK),
    .ADDR_W(ADDR_W)
  ) uRdAddr (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .clear_i(startAcc),
    .step_i (in_rd_o),
    .addr_o (rdAddr),
    .last_o (rdLast)
  );

  dct_tile_addr_gen #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .BLK   (BLK),
    .ADDR_W(ADDR_W)
  ) uWrAddr (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .clear_i(startAcc),
    .step_i (out_we_o),
    .addr_o (wrAddr),
    .last_o (wrLast)
  );

endmodule

// File: doc/dct_tile_sequencer.md
# dct_tile_sequencer

Parametrised frame sequencer for the 2D-DCT datapath: on `start` it reads an IMG_W×IMG_H image from the input memory in BLK×BLK tile order, streams each tile into the DCT core over a valid/ready handshake, writes the core's results back to the output memory at the same tiled addresses, and pulses `done` when the last coefficient is written. It replaces fixed-delay dumping in the memory-test top, supports any tile-aligned image size, and signals completion explicitly.

## Interface
- `IMG_W`, 128, image width in pixels (multiple of BLK)
- `IMG_H`, 128, image height in pixels (multiple of BLK)
- `BLK`, 8, tile edge (power of two, ≥2)
- `DATA_W`, 8, input pixel width
- `COEF_W`, 16, DCT coefficient width
- `ADDR_W`, 14, memory address width (≥ clog2(IMG_W·IMG_H))

- `clk` in 1 — single clock, rising edge
- `rstn` in 1 — asynchronous, active-low reset
- `start` in 1 — one-cycle request to process one frame
- `busy` out 1 — high from accepted start until done
- `done` out 1 — one-cycle pulse after final write
- `err` out 1 — sticky: result beat arrived with no pending write; cleared by next accepted start
- `in_rd` out 1 — input memory read enable
- `in_addr` out ADDR_W — input read address
- `in_data` in DATA_W — read data, valid exactly 1 cycle after `in_rd`
- `s_valid` out 1, `s_ready` in 1, `s_data` out DATA_W, `s_last` out 1 — pixel stream to DCT core
- `m_valid` in 1, `m_data` in COEF_W, `m_last` in 1 — coefficient stream from core (no backpressure)
- `out_we` out 1, `out_addr` out ADDR_W, `out_data` out COEF_W — output memory write port

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: `start`=1 → clear counters and `err`, go RUN. `start` in any other state is ignored.
- RUN: reads issued in tile order: column c fastest, then row r, then tile x bx, then tile y by. Address = (by·BLK + r)·IMG_W + bx·BLK + c, formed by incremental adders (no multipliers).
- Read data lands in a 2-entry skid FIFO feeding `s_*`. `in_rd` asserted only when FIFO occupancy + reads in flight < 2; no beat is ever dropped or duplicated.
- `s_last`=1 on the BLK²-th beat of each tile.
- Last read issued → DRAIN.
- Write side: independent counter set with identical ordering; each `m_valid` beat writes `m_data` to the next tiled address in the same cycle (`out_we`=`m_valid`, combinational). `m_last` is not used for addressing.
- DRAIN: last write (write count = IMG_W·IMG_H) → DONE. DONE lasts one cycle, `done`=1, then IDLE.
- `m_valid` in IDLE/DONE or after the final write: beat dropped, `out_we`=0, `err` set.

## Timing
- Reset values: `busy`, `done`, `err`, `in_rd`, `s_valid`, `s_last`, `out_we` = 0; `in_addr`, `out_addr`, `s_data`, `out_data` = 0; state IDLE.
- `start` at cycle t → `busy`=1 and first `in_rd` at t+1 (address 0); first `s_valid` at t+2.
- With `s_ready` held high: one pixel per cycle, IMG_W·IMG_H+1 cycles from first `in_rd` to last `s_valid`.
- `done` asserted the cycle after the final `out_we`; `busy` falls the same cycle `done` falls.
- `rstn` low mid-frame: all state cleared asynchronously; in-flight read data discarded; no `done`.
- Simultaneous final write and stray `m_valid` cannot occur (one beat per cycle).

## Structure
- Package `dct_seq_pkg`: state enum, default BLK/DATA_W/COEF_W constants, `clog2` helper.
- Sub-module `dct_tile_addr_gen` (parameters IMG_W, IMG_H, BLK, ADDR_W; ports clk, rstn, clear, step, addr, last): the c/r/bx/by counter set with incremental address; instantiated twice (read, write).
- Skid FIFO kept inline.

## Test plan
- IMG_W=IMG_H=16, BLK=8, `s_ready`=1, core model = 4-cycle passthrough → read addresses 0–7, 16–23, …, 112–119, then 8–15…; `s_last` on beats 64/128/192/256; 256 writes; `done` once.
- Same, `s_ready` random 50% → exactly 256 `in_rd`, 256 `s_valid`∧`s_ready` beats, stream order identical to the unstalled run.
- Default 128×128 with image file input → 16384 writes, `out_addr` covers 0–16383 once each, `done` pulse.
- `start` pulsed during RUN and DRAIN → ignored; single `done`, counts unchanged.
- `rstn` low at pixel 100, then new `start` → all outputs 0 during reset; second frame completes with correct addresses from 0.
- `m_valid` injected in IDLE → no `out_we`, `err`=1; next `start` clears `err`.
